// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - valid/ready command stream to APB3 master bridge, one transfer in flight
module apb_master_bridge #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cmd_ready_q;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                    state_d  = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // pready takes priority over a timeout hitting on the same edge
                if (pready) begin
                    rdata_d = pwrite_q ? '0 : prdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(LIMIT))) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= (state_d == IDLE);
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign psel      = (state_q == SETUP) || (state_q == ACCESS);
    assign penable   = (state_q == ACCESS);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - self-checking bench for apb_master_bridge
module tb_apb_master_bridge;

    localparam int TMO = 16;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [7:0]  paddr;
    logic        psel, penable, pwrite, pready;
    logic [31:0] pwdata, prdata;

    int checks = 0;
    int errors = 0;

    apb_master_bridge #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .pclk(pclk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .pready(pready), .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [31:0] srd;
        int          waits;
        int          bp;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_acc;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Slave holds pready low for 'waits' ACCESS cycles; response held off for 'bp' cycles.
    task automatic run_xfer(input vec_t v);
        int t;
        int n;
        logic [31:0] exp_pw;
        exp_pw    = v.wr ? v.wd : 32'h0;
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wd;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge pclk);
            t++;
        end
        chk("cmd_ready_wait", {31'b0, cmd_ready}, 32'h1);
        @(negedge pclk);
        cmd_valid = 1'b0;
        cmd_addr  = ~v.addr;
        cmd_wdata = ~v.wd;
        chk("setup_psel", {31'b0, psel}, 32'h1);
        chk("setup_penable", {31'b0, penable}, 32'h0);
        chk("setup_paddr", {24'b0, paddr}, {24'b0, v.addr});
        chk("setup_pwrite", {31'b0, pwrite}, {31'b0, v.wr});
        chk("setup_pwdata", pwdata, exp_pw);
        pready = 1'b1;
        prdata = $urandom;
        @(negedge pclk);
        n = 0;
        while (psel && penable && n < 200) begin
            chk("access_paddr", {24'b0, paddr}, {24'b0, v.addr});
            chk("access_pwdata", pwdata, exp_pw);
            pready = (n >= v.waits);
            prdata = pready ? v.srd : $urandom;
            n++;
            @(negedge pclk);
        end
        pready = 1'b0;
        prdata = $urandom;
        chk("access_cycles", n, v.exp_acc);
        chk("resp_psel", {31'b0, psel}, 32'h0);
        chk("resp_valid", {31'b0, rsp_valid}, 32'h1);
        chk("resp_rdata", rsp_rdata, v.exp_rdata);
        chk("resp_err", {31'b0, rsp_err}, {31'b0, v.exp_err});
        chk("resp_paddr_hold", {24'b0, paddr}, {24'b0, v.addr});
        for (int i = 0; i < v.bp; i++) begin
            cmd_valid = 1'b1;
            cmd_addr  = 8'hEE;
            @(negedge pclk);
            chk("bp_valid", {31'b0, rsp_valid}, 32'h1);
            chk("bp_rdata", rsp_rdata, v.exp_rdata);
            chk("bp_cmd_ready", {31'b0, cmd_ready}, 32'h0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        chk("post_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("post_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    endtask

    function automatic vec_t model(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                                   input logic [31:0] srd, input int waits, input int bp);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wd = wd; v.srd = srd; v.waits = waits; v.bp = bp;
        if (waits >= TMO) begin
            v.exp_rdata = 32'h0;
            v.exp_err   = 1'b1;
            v.exp_acc   = TMO;
        end else begin
            v.exp_rdata = wr ? 32'h0 : srd;
            v.exp_err   = 1'b0;
            v.exp_acc   = waits + 1;
        end
        return v;
    endfunction

    initial begin
        vecs[0] = '{1'b1, 8'h04, 32'hDEADBEEF, 32'h0,        0,   0, 32'h0,        1'b0, 1};
        vecs[1] = '{1'b0, 8'h04, 32'h0,        32'hDEADBEEF, 0,   0, 32'hDEADBEEF, 1'b0, 1};
        vecs[2] = '{1'b1, 8'h08, 32'h12345678, 32'h0,        3,   0, 32'h0,        1'b0, 4};
        vecs[3] = '{1'b0, 8'h10, 32'h0,        32'h55AA55AA, 999, 0, 32'h0,        1'b1, 16};
        vecs[4] = '{1'b0, 8'h20, 32'h0,        32'hCAFEF00D, 0,   5, 32'hCAFEF00D, 1'b0, 1};
        vecs[5] = '{1'b0, 8'h30, 32'h0,        32'hA5A5A5A5, 15,  0, 32'hA5A5A5A5, 1'b0, 16};
        vecs[6] = '{1'b1, 8'hFF, 32'hFFFFFFFF, 32'h0,        16,  1, 32'h0,        1'b1, 16};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h0; cmd_wdata = 32'h0;
        rsp_ready = 1'b0; pready = 1'b0; prdata = 32'h0;
        repeat (3) @(negedge pclk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'h0);
        chk("rst_psel", {31'b0, psel}, 32'h0);
        chk("rst_penable", {31'b0, penable}, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_paddr", {24'b0, paddr}, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        rst_n = 1'b1;
        @(negedge pclk);
        chk("rel_cmd_ready", {31'b0, cmd_ready}, 32'h1);

        for (int i = 0; i < 7; i++) run_xfer(vecs[i]);

        // reset while in ACCESS drops the transfer with no response
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h40; cmd_wdata = 32'h01020304;
        @(negedge pclk);
        cmd_valid = 1'b0; pready = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        chk("pre_rst_penable", {31'b0, penable}, 32'h1);
        rst_n = 1'b0;
        @(negedge pclk);
        chk("midrst_psel", {31'b0, psel}, 32'h0);
        chk("midrst_penable", {31'b0, penable}, 32'h0);
        chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("midrst_cmd_ready", {31'b0, cmd_ready}, 32'h0);
        rst_n = 1'b1;
        @(negedge pclk);
        chk("midrst_rel_ready", {31'b0, cmd_ready}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            chk("midrst_no_rsp", {31'b0, rsp_valid | psel}, 32'h0);
        end

        for (int i = 0; i < 25; i++) begin
            vec_t v;
            v = model(1'($urandom_range(0, 1)), 8'($urandom), $urandom, $urandom,
                      int'($urandom_range(0, 20)), int'($urandom_range(0, 3)));
            run_xfer(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
